eth_port_reset_sequencer: RTL and testbench

Per-port reset sequencer for the Ethernet hard-IP port. It drives the active-low o_rst_n / o_tx_rst_n / o_rx_rst_n towards the IP and closes the handshake on the matching ack inputs. It gates each release on PLL, TX-lane and PCS status, and recovers automatically from RX link loss and lost system PLL lock. It sits between the user CSR space (software restart request, status readback) and the IP reset inputs, and runs in the csr_clk domain.

---
 rtl/eth_rst_seq_pkg.sv | 25 ++
 rtl/eth_rst_seq_timer.sv | 41 ++++
 rtl/eth_port_reset_sequencer.sv | 178 +++++++++++++++++
 tb/tb_eth_port_reset_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rst_seq_pkg.sv
// eth_rst_seq_pkg
// Shared definitions for the Ethernet port reset sequencer: the state
// encoding seen on the CSR readback and the LINK_UP loss glitch filter length.
package eth_rst_seq_pkg;

    typedef enum logic [3:0] {
        ST_WAIT_SYS_PLL = 4'd0,
        ST_ASSERT_ACK   = 4'd1,
        ST_HOLD         = 4'd2,
        ST_TX_RELEASE   = 4'd3,
        ST_RX_RELEASE   = 4'd4,
        ST_LINK_UP      = 4'd5,
        ST_RX_RESET     = 4'd6,
        ST_ERROR        = 4'd7
    } seq_state_t;

    // Consecutive cycles of rx_pcs_ready low needed before LINK_UP gives up.
    localparam int GLITCH_CYCLES = 2;

    // States that wait on the IP and must give up after the timeout.
    function automatic logic has_timeout(input seq_state_t s);
        return s inside {ST_ASSERT_ACK, ST_TX_RELEASE, ST_RX_RELEASE, ST_RX_RESET};
    endfunction

endpackage

// File: rtl/eth_rst_seq_timer.sv
// eth_rst_seq_timer
// Loadable down-counter that sticks at zero. Shared between the HOLD
// interval and the per-state wait timeout.
// Ports:
//   csr_clk    - clock
//   reset      - asynchronous active-high reset (count -> 0)
//   clear      - force count to zero
//   load       - load load_value (clear has priority)
//   load_value - value to load; the interval lasts load_value + 1 cycles
//   expired    - count has reached zero
module eth_rst_seq_timer
    import eth_rst_seq_pkg::*;
#(
    parameter int TMR_W = 20
) (
    input  logic             csr_clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [TMR_W-1:0] load_value,
    output logic             expired
);

    logic [TMR_W-1:0] count;

    // Counts down every cycle and stays at zero instead of wrapping.
    always_ff @(posedge csr_clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - TMR_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/eth_port_reset_sequencer.sv
// eth_port_reset_sequencer
// Per-port reset sequencer for the Ethernet hard IP. Drives the active-low
// main/TX/RX resets, waits for the matching acks, gates releases on PLL,
// TX lane and PCS status, and recovers from RX link loss and system PLL loss.
// Ports:
//   csr_clk, reset                  - clock, async active-high reset
//   i_start                         - software restart pulse
//   i_sys_pll_locked                - system PLL lock (synchronised)
//   i_tx_pll_locked, i_tx_lanes_stable, i_rx_pcs_ready - IP status
//   ack_i_rst_n/_tx_rst_n/_rx_rst_n - active-low reset acks from the IP
//   o_rst_n, o_tx_rst_n, o_rx_rst_n - active-low resets to the IP
//   o_state                         - state encoding for CSR readback
//   o_link_up, o_error              - LINK_UP / ERROR indications
//   o_retry_cnt                     - consecutive timeout count (saturating)
module eth_port_reset_sequencer
    import eth_rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TMR_W          = 20,
    parameter int MAX_RETRY      = 3
) (
    input  logic       csr_clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_sys_pll_locked,
    input  logic       i_tx_pll_locked,
    input  logic       i_tx_lanes_stable,
    input  logic       i_rx_pcs_ready,
    input  logic       ack_i_rst_n,
    input  logic       ack_i_tx_rst_n,
    input  logic       ack_i_rx_rst_n,
    output logic       o_rst_n,
    output logic       o_tx_rst_n,
    output logic       o_rx_rst_n,
    output logic [3:0] o_state,
    output logic       o_link_up,
    output logic       o_error,
    output logic [1:0] o_retry_cnt
);

    // Timer intervals are loaded as N-1 so a state lasts exactly N cycles.
    localparam logic [TMR_W-1:0] HOLD_LOAD    = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    seq_state_t       state, next_state;
    logic [1:0]       retry_cnt, retry_next;
    logic [1:0]       low_cnt, low_next;
    logic             rx_hold, rx_hold_next;
    logic             state_change;
    logic             tmr_clear, tmr_load, tmr_expired;
    logic [TMR_W-1:0] tmr_load_value;

    eth_rst_seq_timer #(.TMR_W(TMR_W)) u_timer (
        .csr_clk    (csr_clk),
        .reset      (reset),
        .clear      (tmr_clear),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .expired    (tmr_expired)
    );

    // Next-state logic. Normal transitions are computed first and then
    // overridden in rising priority: timeout, sys PLL loss, software start.
    always_comb begin
        next_state     = state;
        retry_next     = retry_cnt;
        rx_hold_next   = rx_hold;
        low_next       = '0;
        state_change   = 1'b0;
        tmr_clear      = 1'b0;
        tmr_load       = 1'b0;
        tmr_load_value = '0;

        case (state)
            ST_WAIT_SYS_PLL: if (i_sys_pll_locked) next_state = ST_ASSERT_ACK;
            ST_ASSERT_ACK:
                if (!ack_i_rst_n && !ack_i_tx_rst_n && !ack_i_rx_rst_n) next_state = ST_HOLD;
            ST_HOLD: if (tmr_expired) next_state = ST_TX_RELEASE;
            ST_TX_RELEASE:
                if (ack_i_rst_n && ack_i_tx_rst_n && i_tx_pll_locked && i_tx_lanes_stable)
                    next_state = ST_RX_RELEASE;
            ST_RX_RELEASE:
                if (ack_i_rx_rst_n && i_rx_pcs_ready) next_state = ST_LINK_UP;
            ST_LINK_UP: begin
                // Glitch filter: a single low sample of rx_pcs_ready is ignored.
                if (!i_rx_pcs_ready) begin
                    if (low_cnt == 2'(GLITCH_CYCLES - 1)) next_state = ST_RX_RESET;
                    else                                  low_next   = low_cnt + 2'd1;
                end
            end
            ST_RX_RESET: begin
                // First wait for the RX ack, then run the hold interval.
                if (!rx_hold) begin
                    if (!ack_i_rx_rst_n) rx_hold_next = 1'b1;
                end else if (tmr_expired) begin
                    next_state = ST_RX_RELEASE;
                end
            end
            ST_ERROR: next_state = ST_ERROR;
            default:  next_state = ST_WAIT_SYS_PLL;
        endcase

        // The timer doubles as the hold counter once RX_RESET has its ack,
        // so timeout only applies while still waiting for that ack.
        if (has_timeout(state) && tmr_expired && !(state == ST_RX_RESET && rx_hold)) begin
            if (int'(retry_cnt) < MAX_RETRY) begin
                next_state = ST_WAIT_SYS_PLL;
                if (retry_cnt != 2'd3) retry_next = retry_cnt + 2'd1;
            end else begin
                next_state = ST_ERROR;
            end
        end

        if (!i_sys_pll_locked && state != ST_WAIT_SYS_PLL && state != ST_ERROR) begin
            next_state = ST_WAIT_SYS_PLL;
            retry_next = retry_cnt;
        end

        if (i_start) begin
            next_state = ST_WAIT_SYS_PLL;
            retry_next = '0;
        end

        if (next_state == ST_LINK_UP && state != ST_LINK_UP) retry_next = '0;

        state_change = i_start || (next_state != state);

        // Every state change restarts the timer with the interval the new
        // state needs; states that do not time anything keep it at zero.
        if (state_change) begin
            case (next_state)
                ST_HOLD: begin
                    tmr_load       = 1'b1;
                    tmr_load_value = HOLD_LOAD;
                end
                ST_ASSERT_ACK, ST_TX_RELEASE, ST_RX_RELEASE, ST_RX_RESET: begin
                    tmr_load       = 1'b1;
                    tmr_load_value = TIMEOUT_LOAD;
                end
                default: tmr_clear = 1'b1;
            endcase
        end else if (state == ST_RX_RESET && !rx_hold && rx_hold_next) begin
            tmr_load       = 1'b1;
            tmr_load_value = HOLD_LOAD;
        end
    end

    // State and output registers. Reset outputs are decoded from next_state
    // so they change on the same edge as the state itself.
    always_ff @(posedge csr_clk or posedge reset) begin
        if (reset) begin
            state      <= ST_WAIT_SYS_PLL;
            retry_cnt  <= '0;
            low_cnt    <= '0;
            rx_hold    <= 1'b0;
            o_rst_n    <= 1'b0;
            o_tx_rst_n <= 1'b0;
            o_rx_rst_n <= 1'b0;
            o_link_up  <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            state      <= next_state;
            retry_cnt  <= retry_next;
            low_cnt    <= state_change ? 2'd0 : low_next;
            rx_hold    <= state_change ? 1'b0 : rx_hold_next;
            o_rst_n    <= next_state inside {ST_TX_RELEASE, ST_RX_RELEASE, ST_LINK_UP, ST_RX_RESET};
            o_tx_rst_n <= next_state inside {ST_TX_RELEASE, ST_RX_RELEASE, ST_LINK_UP, ST_RX_RESET};
            o_rx_rst_n <= next_state inside {ST_RX_RELEASE, ST_LINK_UP};
            o_link_up  <= (next_state == ST_LINK_UP);
            o_error    <= (next_state == ST_ERROR);
        end
    end

    assign o_state     = state;
    assign o_retry_cnt = retry_cnt;

endmodule

// File: tb/tb_eth_port_reset_sequencer.sv
// tb_eth_port_reset_sequencer
// Directed bench for the Ethernet port reset sequencer with a 100-cycle
// timeout so retry and error paths are reachable quickly.
module tb_eth_port_reset_sequencer;

    logic       csr_clk;
    logic       reset;
    logic       i_start;
    logic       i_sys_pll_locked;
    logic       i_tx_pll_locked;
    logic       i_tx_lanes_stable;
    logic       i_rx_pcs_ready;
    logic       ack_i_rst_n;
    logic       ack_i_tx_rst_n;
    logic       ack_i_rx_rst_n;
    logic       o_rst_n;
    logic       o_tx_rst_n;
    logic       o_rx_rst_n;
    logic [3:0] o_state;
    logic       o_link_up;
    logic       o_error;
    logic [1:0] o_retry_cnt;

    int total = 0;
    int bad   = 0;

    eth_port_reset_sequencer #(
        .HOLD_CYCLES    (16),
        .TIMEOUT_CYCLES (100),
        .TMR_W          (20),
        .MAX_RETRY      (3)
    ) dut (
        .csr_clk           (csr_clk),
        .reset             (reset),
        .i_start           (i_start),
        .i_sys_pll_locked  (i_sys_pll_locked),
        .i_tx_pll_locked   (i_tx_pll_locked),
        .i_tx_lanes_stable (i_tx_lanes_stable),
        .i_rx_pcs_ready    (i_rx_pcs_ready),
        .ack_i_rst_n       (ack_i_rst_n),
        .ack_i_tx_rst_n    (ack_i_tx_rst_n),
        .ack_i_rx_rst_n    (ack_i_rx_rst_n),
        .o_rst_n           (o_rst_n),
        .o_tx_rst_n        (o_tx_rst_n),
        .o_rx_rst_n        (o_rx_rst_n),
        .o_state           (o_state),
        .o_link_up         (o_link_up),
        .o_error           (o_error),
        .o_retry_cnt       (o_retry_cnt)
    );

    // Free-running 10 ns clock.
    initial begin
        csr_clk = 1'b0;
        forever #5 csr_clk = ~csr_clk;
    end

    // Absolute runtime bound in case the sequence never progresses.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] runtime bound exceeded");
    end

    // Advance one clock and settle 1 ns past the edge.
    task automatic tick();
        @(posedge csr_clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Bounded wait for a state; an expired budget counts as a failure.
    task automatic wait_state(input logic [3:0] target, input int budget);
        int waited;
        waited = 0;
        while (o_state !== target && waited < budget) begin
            tick();
            waited++;
        end
        total++;
        if (o_state !== target) begin
            bad++;
            $display("[TB] FAIL wait_state got=%0d exp=%0d", o_state, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_start = 1'b0; i_sys_pll_locked = 1'b0; i_tx_pll_locked = 1'b0;
        i_tx_lanes_stable = 1'b0; i_rx_pcs_ready = 1'b0;
        ack_i_rst_n = 1'b1; ack_i_tx_rst_n = 1'b1; ack_i_rx_rst_n = 1'b1;
        cycles(3);
        total++; if (o_state !== 4'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d exp=0", o_state); end
        total++; if ({o_rst_n, o_tx_rst_n, o_rx_rst_n} !== 3'b000) begin bad++; $display("[TB] FAIL reset_rsts got=%b exp=000", {o_rst_n, o_tx_rst_n, o_rx_rst_n}); end
        total++; if ({o_link_up, o_error, o_retry_cnt} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_flags got=%b exp=0000", {o_link_up, o_error, o_retry_cnt}); end
        reset = 1'b0;
        cycles(5);
        total++; if (o_state !== 4'd0) begin bad++; $display("[TB] FAIL reset_wait_pll got=%0d exp=0", o_state); end
    endtask

    task automatic test_bringup();
        cycles(5);
        i_sys_pll_locked = 1'b1;
        tick();
        total++; if (o_state !== 4'd1) begin bad++; $display("[TB] FAIL bringup_assert_ack got=%0d exp=1", o_state); end
        cycles(2);
        ack_i_rst_n = 1'b0; ack_i_tx_rst_n = 1'b0; ack_i_rx_rst_n = 1'b0;
        tick();
        total++; if (o_state !== 4'd2) begin bad++; $display("[TB] FAIL bringup_hold got=%0d exp=2", o_state); end
        cycles(15);
        total++; if ({o_state, o_tx_rst_n} !== {4'd2, 1'b0}) begin bad++; $display("[TB] FAIL bringup_hold_end got=%0d/%b exp=2/0", o_state, o_tx_rst_n); end
        tick();
        total++; if ({o_state, o_rst_n, o_tx_rst_n, o_rx_rst_n} !== {4'd3, 3'b110}) begin bad++; $display("[TB] FAIL bringup_tx_release got=%0d/%b exp=3/110", o_state, {o_rst_n, o_tx_rst_n, o_rx_rst_n}); end
        ack_i_rst_n = 1'b1; ack_i_tx_rst_n = 1'b1; i_tx_pll_locked = 1'b1; i_tx_lanes_stable = 1'b1;
        tick();
        total++; if ({o_state, o_rx_rst_n} !== {4'd4, 1'b1}) begin bad++; $display("[TB] FAIL bringup_rx_release got=%0d/%b exp=4/1", o_state, o_rx_rst_n); end
        ack_i_rx_rst_n = 1'b1;
        cycles(50);
        total++; if ({o_state, o_link_up} !== {4'd4, 1'b0}) begin bad++; $display("[TB] FAIL bringup_pcs_wait got=%0d/%b exp=4/0", o_state, o_link_up); end
        i_rx_pcs_ready = 1'b1;
        tick();
        total++; if ({o_state, o_link_up, o_retry_cnt} !== {4'd5, 1'b1, 2'd0}) begin bad++; $display("[TB] FAIL bringup_link_up got=%0d/%b/%0d exp=5/1/0", o_state, o_link_up, o_retry_cnt); end
    endtask

    task automatic test_link_loss();
        i_rx_pcs_ready = 1'b0;
        tick();
        i_rx_pcs_ready = 1'b1;
        cycles(3);
        total++; if ({o_state, o_rx_rst_n} !== {4'd5, 1'b1}) begin bad++; $display("[TB] FAIL link_glitch got=%0d/%b exp=5/1", o_state, o_rx_rst_n); end
        i_rx_pcs_ready = 1'b0;
        tick();
        total++; if (o_state !== 4'd5) begin bad++; $display("[TB] FAIL link_loss_first got=%0d exp=5", o_state); end
        tick();
        total++; if ({o_state, o_rst_n, o_tx_rst_n, o_rx_rst_n, o_link_up} !== {4'd6, 4'b1100}) begin bad++; $display("[TB] FAIL link_loss_rx_reset got=%0d/%b exp=6/1100", o_state, {o_rst_n, o_tx_rst_n, o_rx_rst_n, o_link_up}); end
        cycles(3);
        i_rx_pcs_ready = 1'b1;
        ack_i_rx_rst_n = 1'b0;
        tick();
        cycles(15);
        total++; if ({o_state, o_rx_rst_n, o_tx_rst_n} !== {4'd6, 2'b01}) begin bad++; $display("[TB] FAIL link_rx_hold got=%0d/%b exp=6/01", o_state, {o_rx_rst_n, o_tx_rst_n}); end
        tick();
        total++; if ({o_state, o_rx_rst_n} !== {4'd4, 1'b1}) begin bad++; $display("[TB] FAIL link_rx_rerelease got=%0d/%b exp=4/1", o_state, o_rx_rst_n); end
        ack_i_rx_rst_n = 1'b1;
        tick();
        total++; if ({o_state, o_link_up} !== {4'd5, 1'b1}) begin bad++; $display("[TB] FAIL link_reentry got=%0d/%b exp=5/1", o_state, o_link_up); end
    endtask

    task automatic test_timeout_retry();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        total++; if ({o_state, o_retry_cnt} !== {4'd0, 2'd0}) begin bad++; $display("[TB] FAIL timeout_start got=%0d/%0d exp=0/0", o_state, o_retry_cnt); end
        ack_i_rst_n = 1'b0; ack_i_tx_rst_n = 1'b0; ack_i_rx_rst_n = 1'b0;
        i_tx_lanes_stable = 1'b0; i_tx_pll_locked = 1'b0; i_rx_pcs_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            wait_state(4'd3, 60);
            cycles(99);
            total++; if (o_state !== 4'd3) begin bad++; $display("[TB] FAIL timeout_early_%0d got=%0d exp=3", k, o_state); end
            tick();
            if (k < 4) begin
                total++; if ({o_state, o_retry_cnt} !== {4'd0, 2'(k)}) begin bad++; $display("[TB] FAIL timeout_retry_%0d got=%0d/%0d exp=0/%0d", k, o_state, o_retry_cnt, k); end
            end else begin
                total++; if ({o_state, o_error, o_rst_n, o_tx_rst_n, o_rx_rst_n, o_retry_cnt} !== {4'd7, 4'b1000, 2'd3}) begin bad++; $display("[TB] FAIL timeout_error got=%0d/%b/%0d exp=7/1000/3", o_state, {o_error, o_rst_n, o_tx_rst_n, o_rx_rst_n}, o_retry_cnt); end
            end
        end
        cycles(5);
        total++; if ({o_state, o_error} !== {4'd7, 1'b1}) begin bad++; $display("[TB] FAIL error_sticky got=%0d/%b exp=7/1", o_state, o_error); end
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        total++; if ({o_state, o_error, o_retry_cnt} !== {4'd0, 1'b0, 2'd0}) begin bad++; $display("[TB] FAIL error_restart got=%0d/%b/%0d exp=0/0/0", o_state, o_error, o_retry_cnt); end
    endtask

    task automatic test_pll_loss();
        wait_state(4'd3, 60);
        cycles(100);
        total++; if ({o_state, o_retry_cnt} !== {4'd0, 2'd1}) begin bad++; $display("[TB] FAIL pll_pre_retry got=%0d/%0d exp=0/1", o_state, o_retry_cnt); end
        wait_state(4'd3, 60);
        ack_i_rst_n = 1'b1; ack_i_tx_rst_n = 1'b1; i_tx_pll_locked = 1'b1; i_tx_lanes_stable = 1'b1;
        tick();
        total++; if (o_state !== 4'd4) begin bad++; $display("[TB] FAIL pll_rx_release got=%0d exp=4", o_state); end
        i_sys_pll_locked = 1'b0;
        tick();
        total++; if ({o_state, o_rst_n, o_tx_rst_n, o_rx_rst_n, o_retry_cnt} !== {4'd0, 3'b000, 2'd1}) begin bad++; $display("[TB] FAIL pll_loss got=%0d/%b/%0d exp=0/000/1", o_state, {o_rst_n, o_tx_rst_n, o_rx_rst_n}, o_retry_cnt); end
    endtask

    task automatic test_back_to_back();
        i_sys_pll_locked = 1'b1;
        ack_i_rst_n = 1'b0; ack_i_tx_rst_n = 1'b0; ack_i_rx_rst_n = 1'b0;
        i_tx_pll_locked = 1'b0; i_tx_lanes_stable = 1'b0; i_rx_pcs_ready = 1'b0;
        wait_state(4'd3, 60);
        cycles(99);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        total++; if ({o_state, o_retry_cnt} !== {4'd0, 2'd0}) begin bad++; $display("[TB] FAIL start_vs_timeout got=%0d/%0d exp=0/0", o_state, o_retry_cnt); end
    endtask

    task automatic test_async_reset();
        wait_state(4'd3, 60);
        cycles(100);
        total++; if (o_retry_cnt !== 2'd1) begin bad++; $display("[TB] FAIL async_pre_retry got=%0d exp=1", o_retry_cnt); end
        wait_state(4'd3, 60);
        ack_i_rst_n = 1'b1; ack_i_tx_rst_n = 1'b1; i_tx_pll_locked = 1'b1; i_tx_lanes_stable = 1'b1;
        tick();
        ack_i_rx_rst_n = 1'b1; i_rx_pcs_ready = 1'b1;
        tick();
        total++; if ({o_state, o_link_up, o_retry_cnt} !== {4'd5, 1'b1, 2'd0}) begin bad++; $display("[TB] FAIL async_link_retry_clear got=%0d/%b/%0d exp=5/1/0", o_state, o_link_up, o_retry_cnt); end
        #3;
        reset = 1'b1;
        #1;
        total++; if ({o_rst_n, o_tx_rst_n, o_rx_rst_n, o_link_up} !== 4'b0000) begin bad++; $display("[TB] FAIL async_reset_outputs got=%b exp=0000", {o_rst_n, o_tx_rst_n, o_rx_rst_n, o_link_up}); end
        total++; if (o_state !== 4'd0) begin bad++; $display("[TB] FAIL async_reset_state got=%0d exp=0", o_state); end
        #2;
        reset = 1'b0;
        tick();
        total++; if ({o_state, o_rst_n} !== {4'd1, 1'b0}) begin bad++; $display("[TB] FAIL async_restart got=%0d/%b exp=1/0", o_state, o_rst_n); end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_link_loss();
        test_timeout_retry();
        test_pll_loss();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
